chunked_addsub: RTL

CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

---
 rtl/chunked_addsub.sv | 113 +++++++++++
 1 files changed

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle, result after WIDTH/CHUNK RUN cycles.
// Result is held in DONE until out_ready; in_ready only in IDLE, so operations never overlap.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   tot;
  logic             last;
  logic             msb_cin;

  // Working sum lives in res_q so that s keeps the previous result during RUN.
  always_comb begin
    a_ch    = '0;
    b_ch    = '0;
    res_nxt = res_q;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IW'(k)) begin
        a_ch = a_q[k*CHUNK +: CHUNK];
        b_ch = b_q[k*CHUNK +: CHUNK];
      end
    end
    tot = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IW'(k)) begin
        res_nxt[k*CHUNK +: CHUNK] = tot[CHUNK-1:0];
      end
    end
    // Carry into the top bit of the chunk, recovered from its sum bit.
    msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ tot[CHUNK-1];
    last    = (idx_q == LAST);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~ci : ci;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q   <= res_nxt;
          carry_q <= tot[CHUNK];
          if (last) begin
            s   <= res_nxt;
            co  <= tot[CHUNK];
            ovf <= msb_cin ^ tot[CHUNK];
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
